// File: rtl/fpu_pkg.sv
// Shared binary32 constants, the unpacked-operand type and the pipeline stage
// payloads used by the alignment front end.
package fpu_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int MANT_W    = 24;
  localparam int EXT_W     = 27;
  localparam int MAX_SHIFT = 26;
  localparam int SHIFT_W   = 5;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_operand_t;

  typedef struct packed {
    logic [MANT_W-1:0]  big_mant;
    logic [MANT_W-1:0]  small_mant;
    logic [EXP_W-1:0]   exp;
    logic [SHIFT_W-1:0] shift;
    logic               sign_big;
    logic               eff_sub;
    logic               swapped;
    logic               special;
  } align_s1_t;

  typedef struct packed {
    logic [MANT_W-1:0] big_mant;
    logic [EXT_W-1:0]  small_mant;
    logic [EXP_W-1:0]  exp;
    logic              sign_big;
    logic              eff_sub;
    logic              swapped;
    logic              special;
  } align_s2_t;

  // Denormals read as exponent 1 with a clear hidden bit.
  function automatic fp_operand_t fp_unpack(input logic [31:0] raw, input logic flip_sign);
    fp_operand_t u;
    u.sign = raw[31] ^ flip_sign;
    if (raw[EXP_W+FRAC_W-1:FRAC_W] == '0) begin
      u.exp  = 8'd1;
      u.mant = {1'b0, raw[FRAC_W-1:0]};
    end else begin
      u.exp  = raw[EXP_W+FRAC_W-1:FRAC_W];
      u.mant = {1'b1, raw[FRAC_W-1:0]};
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational 27-bit right shifter for the smaller mantissa.
// FPU_ALIGN_STICKY_EN folds every discarded bit into bit 0 (sticky).
module fp_align_shifter
  import fpu_pkg::*;
(
  input  logic [MANT_W-1:0]  mant_in,
  input  logic [SHIFT_W-1:0] shift,
  output logic [EXT_W-1:0]   mant_out
);

  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] shifted;
`ifdef FPU_ALIGN_STICKY_EN
  logic [EXT_W-1:0] lost_mask;
  logic             sticky;
`endif

  always_comb begin
    ext     = {mant_in, 3'b000};
    shifted = ext >> shift;
`ifdef FPU_ALIGN_STICKY_EN
    lost_mask = ({{(EXT_W-1){1'b0}}, 1'b1} << shift) - {{(EXT_W-1){1'b0}}, 1'b1};
    sticky    = |(ext & lost_mask);
    // At full saturation only "something was there" survives.
    if (shift >= SHIFT_W'(MAX_SHIFT)) begin
      mant_out = {{(EXT_W-1){1'b0}}, |mant_in};
    end else begin
      mant_out = {shifted[EXT_W-1:1], shifted[0] | sticky};
    end
`else
    if (shift >= SHIFT_W'(MAX_SHIFT)) begin
      mant_out = '0;
    end else begin
      mant_out = shifted;
    end
`endif
  end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage binary32 operand alignment: stage 1 compares/swaps, stage 2 shifts
// the smaller mantissa. Sticky generation is enabled by FPU_ALIGN_STICKY_EN.
module fp_align_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] big_mant,
  output logic [26:0] small_mant,
  output logic [7:0]  exp_out,
  output logic        sign_big,
  output logic        eff_sub,
  output logic        swapped,
  output logic        special
);

  fp_operand_t      opa;
  fp_operand_t      opb;
  logic             b_gt;
  logic [EXP_W-1:0] exp_diff;
  align_s1_t        s1_new;
  align_s1_t        s1_d, s1_q;
  align_s2_t        s2_d, s2_q;
  logic             s1_valid_d, s1_valid_q;
  logic             s2_valid_d, s2_valid_q;
  logic             s2_adv, s1_adv, in_xfer;
  logic [EXT_W-1:0] aligned;

  always_comb begin
    opa    = fp_unpack(op_a, 1'b0);
    opb    = fp_unpack(op_b, sub_op);
    b_gt   = {opb.exp, opb.mant} > {opa.exp, opa.mant};
    s1_new = '0;
    if (b_gt) begin
      s1_new.big_mant   = opb.mant;
      s1_new.small_mant = opa.mant;
      s1_new.exp        = opb.exp;
      s1_new.sign_big   = opb.sign;
      exp_diff          = opb.exp - opa.exp;
    end else begin
      s1_new.big_mant   = opa.mant;
      s1_new.small_mant = opb.mant;
      s1_new.exp        = opa.exp;
      s1_new.sign_big   = opa.sign;
      exp_diff          = opa.exp - opb.exp;
    end
    s1_new.shift   = (exp_diff > EXP_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT)
                                                    : exp_diff[SHIFT_W-1:0];
    s1_new.eff_sub = opa.sign ^ opb.sign;
    s1_new.swapped = b_gt;
    s1_new.special = (opa.exp == EXP_SPECIAL) || (opb.exp == EXP_SPECIAL);
  end

  fp_align_shifter u_shifter (
    .mant_in  (s1_q.small_mant),
    .shift    (s1_q.shift),
    .mant_out (aligned)
  );

  // Valid/ready: a beat moves on any edge where valid && ready. Stage 2 may
  // advance when empty or drained by out_ready; stage 1 moves into it only
  // then, and in_ready is combinational so a full, stalled pipe refuses input
  // in the same cycle. Registers load only when their stage advances.
  always_comb begin
    s2_adv  = !s2_valid_q || out_ready;
    s1_adv  = s1_valid_q && s2_adv;
    in_xfer = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_d       = s1_new;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_adv) begin
      s2_d.big_mant   = s1_q.big_mant;
      s2_d.small_mant = aligned;
      s2_d.exp        = s1_q.exp;
      s2_d.sign_big   = s1_q.sign_big;
      s2_d.eff_sub    = s1_q.eff_sub;
      s2_d.swapped    = s1_q.swapped;
      s2_d.special    = s1_q.special;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign in_ready   = !s1_valid_q || s2_adv;
  assign out_valid  = s2_valid_q;
  assign big_mant   = s2_q.big_mant;
  assign small_mant = s2_q.small_mant;
  assign exp_out    = s2_q.exp;
  assign sign_big   = s2_q.sign_big;
  assign eff_sub    = s2_q.eff_sub;
  assign swapped    = s2_q.swapped;
  assign special    = s2_q.special;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Scoreboard bench for fp_align_pipe: directed test-plan vectors, stall and
// reset scenarios, then randomized operands with random backpressure.
module tb_fp_align_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        sub_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] big_mant;
  logic [26:0] small_mant;
  logic [7:0]  exp_out;
  logic        sign_big, eff_sub, swapped, special;

`ifdef FPU_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic [62:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          rand_rdy = 1'b0;
  logic        force_rdy = 1'b1;
  logic [62:0] held_val;
  bit          held_v = 1'b0;
  logic [62:0] act_vec;

  fp_align_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .sub_op     (sub_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .exp_out    (exp_out),
    .sign_big   (sign_big),
    .eff_sub    (eff_sub),
    .swapped    (swapped),
    .special    (special)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  assign act_vec = {big_mant, small_mant, exp_out, sign_big, eff_sub, swapped, special};

  // ---------------- reference model ----------------
  function automatic logic [62:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
    int unsigned ea, eb, ma, mb, e_big, e_small, m_big, m_small, diff;
    longint unsigned ext, small_v, lost;
    bit sa, sb, sw, spec, sgn;
    sa   = a[31];
    sb   = b[31] ^ sub;
    ea   = {24'b0, a[30:23]};
    eb   = {24'b0, b[30:23]};
    spec = (ea == 255) || (eb == 255);
    ma   = {9'b0, a[22:0]};
    mb   = {9'b0, b[22:0]};
    if (ea == 0) ea = 1; else ma = ma + 32'h0080_0000;
    if (eb == 0) eb = 1; else mb = mb + 32'h0080_0000;
    sw      = (eb > ea) || ((eb == ea) && (mb > ma));
    e_big   = sw ? eb : ea;
    e_small = sw ? ea : eb;
    m_big   = sw ? mb : ma;
    m_small = sw ? ma : mb;
    sgn     = sw ? sb : sa;
    diff    = e_big - e_small;
    ext     = {32'b0, m_small} * 8;
    if (diff >= 26) begin
      small_v = (STICKY && m_small != 0) ? 64'd1 : 64'd0;
    end else begin
      small_v = ext >> diff;
      lost    = ext & ((64'd1 << diff) - 64'd1);
      if (STICKY && lost != 0) small_v = small_v | 64'd1;
    end
    return {m_big[23:0], small_v[26:0], e_big[7:0], sgn, sa ^ sb, sw, spec};
  endfunction

  function automatic logic [31:0] rand_op();
    int          mode, t;
    logic [7:0]  e;
    logic [31:0] frac;
    mode = $urandom_range(0, 15);
    if (mode == 0)      e = 8'h00;
    else if (mode == 1) e = 8'hFF;
    else if (mode <= 3) e = 8'($urandom_range(0, 255));
    else begin
      t = 127 + int'($urandom_range(0, 40)) - 20;
      e = t[7:0];
    end
    frac = $urandom;
    if ($urandom_range(0, 7) == 0) frac = '0;
    return {1'($urandom_range(0, 1)), e, frac[22:0]};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [62:0] act, input logic [62:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1; leaves in_valid low so idle gaps are clean.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bit done;
    done     = 1'b0;
    op_a     = a;
    op_b     = b;
    sub_op   = sub;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_model(a, b, sub));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_left", 63'(exp_q.size()), 63'd0);
    @(posedge clk);
    #1;
  endtask

  // Single owner of out_ready; applied at posedge+2.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_valid", 63'(out_valid), 63'd1);
        check("stall_stable", act_vec, held_val);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %h, required no output", act_vec);
        end else begin
          check("result", act_vec, exp_q.pop_front());
        end
        held_v = 1'b0;
      end else if (out_valid) begin
        held_v   = 1'b1;
        held_val = act_vec;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    #12;
    check("rst_out_valid", 63'(out_valid), 63'd0);
    check("rst_in_ready", 63'(in_ready), 63'd1);
    check("rst_outputs", act_vec, 63'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // 1.0 + 1.0: latency and literal result
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    check("latency", 63'(lat), 63'd2);
    check("t1_big_mant", 63'(big_mant), 63'h80_0000);
    check("t1_small_mant", 63'(small_mant), 63'h400_0000);
    check("t1_exp", 63'(exp_out), 63'h7F);
    check("t1_swap_effsub", 63'({swapped, eff_sub}), 63'd0);
    @(posedge clk);
    #1;

    send(32'h3F80_0000, 32'h4000_0000, 1'b0);
    send(32'h3F80_0000, 32'h3080_0000, 1'b0);
    send(32'h3F80_0000, 32'h3F80_0000, 1'b1);
    send(32'h7F80_0000, 32'h3F80_0000, 1'b0);
    send(32'h0000_0001, 32'h0000_0003, 1'b1);
    send(32'h3F80_0001, 32'h3400_0007, 1'b0);
    drain();

    // backpressure: two accepted, then in_ready must drop and outputs hold
    force_rdy = 1'b0;
    idle(1);
    send(32'h4040_0000, 32'h3F00_0000, 1'b0);
    send(32'hC120_0000, 32'h4120_0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 63'(in_ready), 63'd0);
      check("full_out_valid", 63'(out_valid), 63'd1);
    end
    @(posedge clk);
    #1;
    force_rdy = 1'b1;
    drain();

    // reset with two transactions in flight
    force_rdy = 1'b0;
    idle(1);
    send(32'h4100_0000, 32'h3F80_0000, 1'b0);
    send(32'h4200_0000, 32'h3F80_0000, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 63'(out_valid), 63'd0);
    check("midrst_in_ready", 63'(in_ready), 63'd1);
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_quiet", 63'(out_valid), 63'd0);
    end
    @(posedge clk);
    #1;
    force_rdy = 1'b1;
    idle(1);
    send(32'h3F80_0000, 32'h4000_0000, 1'b1);
    drain();

    // randomized operands with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b;
      a = rand_op();
      b = ($urandom_range(0, 9) == 0) ? a : rand_op();
      send(a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_rdy  = 1'b0;
    force_rdy = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_align_pipe.md
# fp_align_pipe

- Two-stage pipelined operand-alignment front end for the single-precision FP adder.
- Takes two IEEE-754 binary32 operands and an add/subtract opcode.
- Produces the larger-magnitude mantessa, the right-shifted smaller mantessa (with guard/round/sticky), the common exponent and the effective operation.
- These feed the adder datapath whose output drives the post-add mantessa selection/normalization logic, so this block is the producing end of the left/right mantessa path interface.

## Interface
- No parameters; widths fixed to binary32.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage 1 can accept.
- op_a  input  32  operand A.
- op_b  input  32  operand B.
- sub_op  input  1  1 = A − B.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts.
- big_mant  output  24  hidden bit + fraction of the larger-magnitude operand.
- small_mant  output  27  {hidden bit, fraction, G, R, S} of the smaller operand after shifting.
- exp_out  output  8  exponent of the larger operand (biased; 1 for denormal).
- sign_big  output  1  sign of the larger-magnitude operand.
- eff_sub  output  1  effective subtraction.
- swapped  output  1  B was larger.
- special  output  1  either operand has exponent 255.

## Operation
- Unpack:
  - exponent 0 → hidden bit 0, effective exponent 1.
  - Otherwise hidden bit 1.
  - Sign of B is inverted when sub_op=1.
- Stage 1 (compare/swap):
  - Compare {eff_exp, mantessa}.
  - If B > A, swap and set swapped=1.
  - Ties keep A.
  - shift = exp_big − exp_small, 8-bit unsigned, saturated to 26.
  - eff_sub = sign_a XOR sign_b_eff.
- Stage 2 (align):
  - small_mant = ({small 24-bit mantessa, 3'b000}) >> shift.
  - Bit 0 is then ORed with the OR of every bit shifted out (sticky).
  - shift ≥ 26 → small_mant = 27'h1 if the smaller mantessa is nonzero, else 0.
- Special:
  - special=1 if either exponent is 255.
  - Alignment is still performed; downstream ignores the datapath when special=1.
- Handshake:
  - Valid/ready on both ends. A transfer occurs when valid && ready on the same edge.
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances into stage 2 when s1_valid && stage 2 advances.
  - in_ready = !s1_valid || (stage 2 advances).
  - Outputs are held stable while out_valid && !out_ready.

## Timing
- Latency: 2 cycles from input transfer to out_valid.
- Throughput: 1 per cycle with out_ready held high.
- Reset values:
  - Pipeline registers: s1_valid=0, s2_valid=0.
  - Outputs: out_valid=0, in_ready=1, big_mant=0, small_mant=0, exp_out=0, sign_big=0, eff_sub=0, swapped=0, special=0.
- Reset asserted mid-operation: all in-flight transactions are discarded; no partial output appears after deassertion.
- Full pipeline with out_ready=0: in_ready=0 in that same cycle (combinational); no transaction is lost or duplicated.
- Simultaneous input and output transfer with both stages full: allowed; occupancy stays 2.
- Datapath registers load only on advance. Unused bubble contents are don't-care, but outputs are held while stalled.

## Configuration
- FPU_ALIGN_STICKY_EN defined: sticky bit computed as above (IEEE round-to-nearest support).
- Not defined:
  - small_mant bit 0 is the plain shifted-in bit; discarded bits are truncated.
  - The saturation case yields 0.
  - The OR-reduction logic is removed.

## Structure
- Shared package fpu_pkg holds:
  - constants EXP_W=8, FRAC_W=23, MANT_W=24, EXT_W=27, EXP_SPECIAL=8'hFF, MAX_SHIFT=26;
  - typedef of the unpacked operand struct {sign, exp, mant}.
- One sub-module: fp_align_shifter, the combinational 27-bit right shifter with sticky generation, instantiated in stage 2.

## Test plan
- op_a=0x3F800000, op_b=0x3F800000, sub_op=0 → 2 cycles later: big_mant=0x800000, small_mant=0x4000000, exp_out=0x7F, swapped=0, eff_sub=0.
- op_a=0x3F800000, op_b=0x40000000 → swapped=1, exp_out=0x80, small_mant=0x2000000, big_mant=0x800000.
- op_a=0x3F800000, op_b=0x30800000 (shift 30, saturated) → small_mant=27'h1 with FPU_ALIGN_STICKY_EN, 27'h0 without it.
- op_a=0x3F800000, op_b=0x3F800000, sub_op=1 → eff_sub=1, sign_big=0; op_a=0x7F800000 → special=1.
- Back-to-back inputs with out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepted transactions;
  - outputs are held stable;
  - both transactions emerge in order once out_ready=1.
- Reset (rst_n=0) asserted with 2 transactions in flight → out_valid=0 immediately and in_ready=1; no output after release until new input.
